// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : lane command encodings and sequencer FSM states shared by
//                the input skew sequencer and its lane windows.
// Rev 1.0
// ============================================================================
package systolic_pkg;

  localparam int DEFAULT_ARR_SIZE = 4;

  localparam logic [1:0] LANE_IDLE  = 2'b00;
  localparam logic [1:0] LANE_LOAD  = 2'b01;
  localparam logic [1:0] LANE_DRAIN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_FLUSH = 2'b11
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/skew_window.sv
`default_nettype none
// ============================================================================
// skew_window : drain enable for one lane, high while LANE <= d < LANE+count.
// Rev 1.0
// ============================================================================
module skew_window #(
  parameter int LANE  = 0,
  parameter int D_W   = 5,
  parameter int CNT_W = 4
) (
  input  logic [D_W-1:0]   i_d,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_drain_en
);

  localparam logic [D_W-1:0] LANE_IDX = D_W'(LANE);

  // One extra bit so LANE+count cannot wrap.
  logic [D_W:0] upper;
  assign upper      = {1'b0, LANE_IDX} + (D_W + 1)'(i_count);
  assign o_drain_en = (i_d >= LANE_IDX) && ({1'b0, i_d} < upper);

endmodule
`default_nettype wire

// File: rtl/input_skew_sequencer.sv
`default_nettype none
// ============================================================================
// input_skew_sequencer : broadcasts row-vectors into the lane FIFOs, then
//                        drains them with a one-cycle-per-lane diagonal skew.
//                        Optional macro SKEW_FLUSH_EN adds a zero-wavefront
//                        FLUSH phase of ARR_SIZE cycles after each drain.
// Rev 1.0
// ============================================================================
module input_skew_sequencer
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE = DEFAULT_ARR_SIZE,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = ARR_SIZE * 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ARR_SIZE*DATA_W-1:0]   in_data,
  input  logic                         in_last,
  output logic [2*ARR_SIZE-1:0]        lane_state,
  output logic [ARR_SIZE*DATA_W-1:0]   lane_data,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int D_W   = $clog2(DEPTH + ARR_SIZE) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef SKEW_FLUSH_EN
  localparam logic [D_W-1:0] FLUSH_LAST = D_W'(ARR_SIZE - 1);
`endif

  seq_state_e                  state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [D_W-1:0]              dcnt_q, dcnt_d;
  logic [2*ARR_SIZE-1:0]       lane_state_q, lane_state_d;
  logic [ARR_SIZE*DATA_W-1:0]  lane_data_q, lane_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        accept;
  logic [D_W-1:0]              drain_last;
  logic [ARR_SIZE-1:0]         drain_en;

  assign in_ready   = (state_q == ST_IDLE) ||
                      ((state_q == ST_LOAD) && (count_q != DEPTH_C));
  assign accept     = in_valid & in_ready;
  assign drain_last = D_W'(count_q) + D_W'(ARR_SIZE - 2);

  for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
    skew_window #(
      .LANE  (gi),
      .D_W   (D_W),
      .CNT_W (CNT_W)
    ) u_win (
      .i_d        (dcnt_q),
      .i_count    (count_q),
      .o_drain_en (drain_en[gi])
    );
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dcnt_d       = dcnt_q;
    lane_data_d  = lane_data_q;
    lane_state_d = '0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          count_d = (state_q == ST_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
          dcnt_d  = '0;
          // A full block drains regardless of in_last.
          if (in_last || (count_d == DEPTH_C)) state_d = ST_DRAIN;
          else                                 state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        for (int i = 0; i < ARR_SIZE; i++)
          lane_state_d[2*i +: 2] = drain_en[i] ? LANE_DRAIN : LANE_IDLE;
        if (dcnt_q == drain_last) begin
`ifdef SKEW_FLUSH_EN
          state_d = ST_FLUSH;
          dcnt_d  = '0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          dcnt_d = dcnt_q + D_W'(1);
        end
      end
`ifdef SKEW_FLUSH_EN
      ST_FLUSH: begin
        if (dcnt_q == FLUSH_LAST) state_d = ST_IDLE;
        else                      dcnt_d  = dcnt_q + D_W'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      lane_state_d = {ARR_SIZE{LANE_LOAD}};
      lane_data_d  = in_data;
    end

    // Outputs trail the FSM by one cycle, so busy covers the last command
    // cycle and done lands in the first cycle with no command left.
    busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    done_d = busy_q && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      dcnt_q       <= '0;
      lane_state_q <= '0;
      lane_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dcnt_q       <= dcnt_d;
      lane_state_q <= lane_state_d;
      lane_data_q  <= lane_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lane_state = lane_state_q;
  assign lane_data  = lane_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_input_skew_sequencer.sv
`default_nettype none
// ============================================================================
// tb_input_skew_sequencer : directed and randomized blocks checked every cycle
//                           against a per-cycle command schedule model.
// Rev 1.0
// ============================================================================
module tb_input_skew_sequencer;

  localparam int ARR   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = ARR * 2;
  localparam int NCYC  = 2048;
  localparam int LW    = 2 * ARR;
  localparam int DWA   = ARR * DW;
`ifdef SKEW_FLUSH_EN
  localparam int FLUSH_EXTRA = ARR;
`else
  localparam int FLUSH_EXTRA = 0;
`endif
  localparam int DONE_K = 7 + FLUSH_EXTRA;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic [DWA-1:0] in_data = '0;
  logic           in_ready;
  logic [LW-1:0]  lane_state;
  logic [DWA-1:0] lane_data;
  logic           busy;
  logic           done;

  input_skew_sequencer #(
    .ARR_SIZE (ARR),
    .DATA_W   (DW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .lane_state (lane_state),
    .lane_data  (lane_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  bit run_cmp = 1'b0;

  // Model: expected outputs after each counted clock edge.
  logic [LW-1:0]  exp_ls   [NCYC];
  bit             exp_busy [NCYC];
  bit             exp_done [NCYC];
  logic [DWA-1:0] exp_data_now = '0;
  int             blk_count = 0;
  int             blk_start = 0;
  int             blocked_until = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_clear(input int from);
    for (int j = from; j < NCYC; j++) begin
      exp_ls[j]   = '0;
      exp_busy[j] = 1'b0;
      exp_done[j] = 1'b0;
    end
    exp_data_now  = '0;
    blk_count     = 0;
    blocked_until = -1;
  endtask

  // Block of blk_count rows closed at edge m: lane i drains after edges m+1+i .. m+count+i.
  task automatic close_block(input int m);
    int x;
    for (int i = 0; i < ARR; i++)
      for (int k = 1; k <= blk_count; k++)
        exp_ls[m + k + i][2*i +: 2] = 2'b10;
    x = m + blk_count + ARR - 1 + FLUSH_EXTRA;
    for (int j = blk_start; j <= x; j++) exp_busy[j] = 1'b1;
    exp_done[x + 1] = 1'b1;
    blocked_until   = x;
    blk_count       = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [DWA-1:0] dat, input bit last, output bit acc);
    bit rdy;
    int m;
    in_valid = v;
    in_data  = dat;
    in_last  = last;
    #1;
    m   = edge_n + 1;
    rdy = (m > blocked_until) && (blk_count < DEPTH);
    check("in_ready", 128'(in_ready), 128'(rdy));
    acc = v && rdy;
    @(posedge clk);
    edge_n = m;
    if (acc) begin
      exp_ls[m]    = {ARR{2'b01}};
      exp_data_now = dat;
      if (blk_count == 0) blk_start = m;
      blk_count++;
      if (last || (blk_count == DEPTH)) close_block(m);
    end
    if (blk_count > 0) exp_busy[m] = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [DWA-1:0] dat, input bit last, output int held);
    bit a;
    a    = 1'b0;
    held = 0;
    while (!a && held < 64) begin
      step(1'b1, dat, last, a);
      if (!a) held++;
    end
    if (!a) begin
      vectors++;
      miscompares++;
      $display("FAIL send_beat: accepted 0, expected 1 within %0d cycles", held);
    end
  endtask

  task automatic wait_idle();
    bit a;
    int n;
    n = 0;
    while ((blocked_until >= edge_n + 1) && n < 64) begin
      step(1'b0, '0, 1'b0, a);
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: still draining after %0d cycles, expected idle", n);
    end
    step(1'b0, '0, 1'b0, a);
    step(1'b0, '0, 1'b0, a);
  endtask

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      check("lane_state", 128'(lane_state), 128'(exp_ls[edge_n]));
      check("lane_data",  128'(lane_data),  128'(exp_data_now));
      check("busy",       128'(busy),       128'(exp_busy[edge_n]));
      check("done",       128'(done),       128'(exp_done[edge_n]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int held;
    int k;
    logic [DWA-1:0] d;

    model_clear(0);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset lane_state", 128'(lane_state), 128'(0));
    check("reset lane_data",  128'(lane_data),  128'(0));
    check("reset busy",       128'(busy),       128'(0));
    check("reset done",       128'(done),       128'(0));
    check("reset in_ready",   128'(in_ready),   128'(1));
    @(negedge clk);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    // Three-beat block with hand-computed drain pattern.
    step(1'b1, 64'h0101_0101_0101_0101, 1'b0, a);
    check("t1 first load", 128'(lane_state), 128'(8'h55));
    check("t1 first data", 128'(lane_data), 128'(64'h0101_0101_0101_0101));
    step(1'b1, 64'h0202_0202_0202_0202, 1'b0, a);
    step(1'b1, 64'h0303_0303_0303_0303, 1'b1, a);
    for (int kk = 1; kk <= DONE_K; kk++) begin
      step(1'b0, '0, 1'b0, a);
      if (kk == 1) check("t1 k1 lanes", 128'(lane_state), 128'(8'h02));
      if (kk == 3) check("t1 k3 lanes", 128'(lane_state), 128'(8'h2A));
      if (kk == 4) check("t1 k4 lanes", 128'(lane_state), 128'(8'hA8));
      if (kk == 6) check("t1 k6 lanes", 128'(lane_state), 128'(8'h80));
      if (kk == DONE_K) begin
        check("t1 done", 128'(done), 128'(1));
        check("t1 busy", 128'(busy), 128'(0));
      end
    end
    wait_idle();

    // Full block without in_last, then a ninth beat held off until done.
    for (int b = 0; b < DEPTH; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, 1'b0, held);
    end
    send_beat(64'h0909_0909_0909_0909, 1'b1, held);
    check("t2 ninth beat held cycles", 128'(held), 128'(11 + FLUSH_EXTRA));
    wait_idle();

    // Single beat with in_last straight from idle.
    send_beat(64'hA5A5_5A5A_1234_8765, 1'b1, held);
    k = 0;
    while (k < 20 && done !== 1'b1) begin
      step(1'b0, '0, 1'b0, a);
      k++;
    end
    check("t3 cycles to done", 128'(k), 128'(5 + FLUSH_EXTRA));
    wait_idle();

    // in_valid toggling during load.
    for (int b = 0; b < 12; b++) begin
      d = {$urandom, $urandom};
      step(b % 2 == 0, d, b == 10, a);
    end
    wait_idle();

    // Asynchronous reset in the middle of a drain.
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, b == 3, held);
    end
    step(1'b0, '0, 1'b0, a);
    step(1'b0, '0, 1'b0, a);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5 rst lane_state", 128'(lane_state), 128'(0));
    check("t5 rst busy",       128'(busy),       128'(0));
    check("t5 rst done",       128'(done),       128'(0));
    check("t5 rst lane_data",  128'(lane_data),  128'(0));
    model_clear(edge_n);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 64'h0101_0101_0101_0101, 1'b0, a);
    step(1'b1, 64'h0202_0202_0202_0202, 1'b0, a);
    step(1'b1, 64'h0303_0303_0303_0303, 1'b1, a);
    wait_idle();

    // Randomized traffic.
    for (int b = 0; b < 400; b++) begin
      d = {$urandom, $urandom};
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 3) == 0, a);
    end
    if (blk_count > 0) send_beat({$urandom, $urandom}, 1'b1, held);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
